regfile_wb_arbiter: RTL and testbench

- Drives the single write port (we3/addr3/write3) of the CPU register file.
- Merges two writers: the in-order pipeline WB stage, and results from long-latency units (mul/div) arriving by valid/ready handshake.
- Keeps a per-register pending scoreboard so decode can stall on operands whose long-latency result is not yet written.
- Sits between the WB stage / mul-div unit and the register file.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/wb_fifo.sv | 60 ++++++
 rtl/regfile_wb_arbiter.sv | 137 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry, write-request record and
// the write-port select encoding used by the register-file write arbiter.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_WB,
        SEL_FIFO
    } wr_sel_e;

    // A request only reaches the register file if it targets a real register.
    function automatic logic is_live(input wb_req_t req);
        return req.valid && (req.addr != REG_ZERO);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding deferred long-latency results (address + data)
// until the register-file write port has a free slot.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] push_addr,
    input  logic [XLEN-1:0]       push_data,
    input  logic                  pop,
    output logic [REG_ADDR_W-1:0] head_addr,
    output logic [XLEN-1:0]       head_data,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [REG_ADDR_W-1:0] mem_addr [DEPTH];
    logic [XLEN-1:0]       mem_data [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;

    assign full      = (count == (PTR_W + 1)'(DEPTH));
    assign empty     = (count == '0);
    assign head_addr = mem_addr[rd_ptr];
    assign head_data = mem_data[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= push_addr;
            mem_data[wr_ptr] <= push_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) !(push && full && !pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n) !(pop && empty));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline WB has priority, deferred mul/div
// results drain from a FIFO in idle slots, and a pending scoreboard feeds decode.
module regfile_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_addr,
    input  logic [31:0] ld_data,
    input  logic        iss_valid,
    input  logic [4:0]  iss_addr,
    input  logic [4:0]  q1_addr,
    input  logic [4:0]  q2_addr,
    input  logic [4:0]  qd_addr,
    output logic        q1_busy,
    output logic        q2_busy,
    output logic        qd_busy,
    output logic        wb_hold,
    output logic        we3,
    output logic [4:0]  addr3,
    output logic [31:0] write3
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    wb_req_t               wb_req;
    wr_sel_e               sel;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic [REG_ADDR_W-1:0] head_addr;
    logic [XLEN-1:0]       head_data;
    logic [NUM_REGS-1:0]   pending;
    logic [NUM_REGS-1:0]   set_mask;
    logic [NUM_REGS-1:0]   clr_mask;
    logic [CNT_W-1:0]      starve_cnt;

    assign wb_req = '{valid: wb_valid, addr: wb_addr, data: wb_data};

    always_comb begin
        sel = SEL_NONE;
        if (!reset_n)
            sel = SEL_NONE;
        else if (is_live(wb_req))
            sel = SEL_WB;
        else if (!fifo_empty)
            sel = SEL_FIFO;
    end

    always_comb begin
        we3    = 1'b0;
        addr3  = REG_ZERO;
        write3 = '0;
        case (sel)
            SEL_WB: begin
                we3    = 1'b1;
                addr3  = wb_req.addr;
                write3 = wb_req.data;
            end
            SEL_FIFO: begin
                we3    = 1'b1;
                addr3  = head_addr;
                write3 = head_data;
            end
            default: ;
        endcase
    end

    // Ready depends on current occupancy only, so a full FIFO never sees push+pop.
    assign ld_ready = reset_n && !fifo_full;
    assign push     = ld_valid && ld_ready && (ld_addr != REG_ZERO);
    assign pop      = (sel == SEL_FIFO);

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_addr (ld_addr),
        .push_data (ld_data),
        .pop       (pop),
        .head_addr (head_addr),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Saturating count of slots the current head has lost to the pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            starve_cnt <= '0;
        else if (fifo_empty || pop)
            starve_cnt <= '0;
        else if (sel == SEL_WB && starve_cnt != CNT_W'(STARVE_MAX))
            starve_cnt <= starve_cnt + 1'b1;
    end

    assign wb_hold = reset_n && !fifo_empty && (starve_cnt == CNT_W'(STARVE_MAX - 1));

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (iss_valid && iss_addr != REG_ZERO) set_mask[iss_addr] = 1'b1;
        if (pop) clr_mask[head_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pending <= '0;
        else
            pending <= ((pending & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
    end

    function automatic logic busy_of(input logic [REG_ADDR_W-1:0] q);
        return pending[q] || (iss_valid && iss_addr == q && q != REG_ZERO);
    endfunction

    assign q1_busy = reset_n && busy_of(q1_addr);
    assign q2_busy = reset_n && busy_of(q2_addr);
    assign qd_busy = reset_n && busy_of(qd_addr);

    // Re-issuing to a pending register is illegal unless its result is being written now.
    a_no_reissue: assert property (@(posedge clk) disable iff (!reset_n)
        (iss_valid && iss_addr != REG_ZERO && !(pop && head_addr == iss_addr))
            |-> !pending[iss_addr]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised and directed bench for regfile_wb_arbiter, checked every cycle
// against a queue/array reference model of the arbitration rules.
module tb_regfile_wb_arbiter;

    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic [4:0]  q1_addr, q2_addr, qd_addr;
    logic        q1_busy, q2_busy, qd_busy;
    logic        wb_hold;
    logic        we3;
    logic [4:0]  addr3;
    logic [31:0] write3;

    regfile_wb_arbiter #(
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .q1_addr   (q1_addr),
        .q2_addr   (q2_addr),
        .qd_addr   (qd_addr),
        .q1_busy   (q1_busy),
        .q2_busy   (q2_busy),
        .qd_busy   (qd_busy),
        .wb_hold   (wb_hold),
        .we3       (we3),
        .addr3     (addr3),
        .write3    (write3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t       fq[$];
    bit         pend[32];
    int         head_wait;
    bit         hold_prev;
    bit         ld_taken;
    logic [4:0] inflight[$];

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_busy(input logic [4:0] q);
        if (!reset_n) return 1'b0;
        return pend[q] || (iss_valid && iss_addr == q && q != 5'd0);
    endfunction

    // Called at posedge+1 with inputs driven; compares the settled outputs.
    task automatic settle();
        bit          e_we, e_rdy, e_hold;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        #3;
        e_we = 1'b0; e_a = 5'd0; e_d = 32'd0; e_rdy = 1'b0; e_hold = 1'b0;
        if (reset_n) begin
            e_rdy  = (fq.size() < DEPTH);
            e_hold = (fq.size() > 0) && (head_wait == STARVE_MAX - 1);
            if (wb_valid && wb_addr != 5'd0) begin
                e_we = 1'b1; e_a = wb_addr; e_d = wb_data;
            end else if (fq.size() > 0) begin
                e_we = 1'b1; e_a = fq[0].a; e_d = fq[0].d;
            end
        end
        chk("we3", 32'(we3), 32'(e_we));
        chk("addr3", 32'(addr3), 32'(e_a));
        chk("write3", write3, e_d);
        chk("ld_ready", 32'(ld_ready), 32'(e_rdy));
        chk("wb_hold", 32'(wb_hold), 32'(e_hold));
        chk("q1_busy", 32'(q1_busy), 32'(model_busy(q1_addr)));
        chk("q2_busy", 32'(q2_busy), 32'(model_busy(q2_addr)));
        chk("qd_busy", 32'(qd_busy), 32'(model_busy(qd_addr)));
        hold_prev = e_hold;
    endtask

    // Advances the model across the clock edge, then returns at posedge+1.
    task automatic tick();
        bit wb_live, fifo_pop, rdy;
        @(posedge clk);
        if (!reset_n) begin
            fq.delete();
            foreach (pend[i]) pend[i] = 1'b0;
            head_wait = 0;
            ld_taken  = 1'b0;
        end else begin
            wb_live  = wb_valid && wb_addr != 5'd0;
            fifo_pop = !wb_live && fq.size() > 0;
            rdy      = fq.size() < DEPTH;
            ld_taken = ld_valid && rdy;
            if (fq.size() == 0 || fifo_pop) head_wait = 0;
            else head_wait++;
            if (fifo_pop) begin
                pend[fq[0].a] = 1'b0;
                void'(fq.pop_front());
            end
            if (ld_taken && ld_addr != 5'd0) fq.push_back('{a: ld_addr, d: ld_data});
            if (iss_valid && iss_addr != 5'd0) pend[iss_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid = 0; wb_addr = 0; wb_data = 0;
        ld_valid = 0; ld_addr = 0; ld_data = 0;
        iss_valid = 0; iss_addr = 0;
        q1_addr = 0; q2_addr = 0; qd_addr = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        head_wait = 0; hold_prev = 0; ld_taken = 0;
        foreach (pend[i]) pend[i] = 1'b0;
        @(posedge clk); #1;

        // Reset state with a live WB request present.
        wb_valid = 1; wb_addr = 3; wb_data = 32'h11; iss_valid = 1; iss_addr = 4; q1_addr = 4;
        settle();
        chk("rst_we3", 32'(we3), 0);
        chk("rst_ld_ready", 32'(ld_ready), 0);
        tick();
        idle_inputs();
        settle(); tick();
        reset_n = 1'b1;
        settle(); tick();

        // Plain WB write, then r0 as an idle slot.
        wb_valid = 1; wb_addr = 3; wb_data = 32'h11;
        settle();
        chk("wb_addr3", 32'(addr3), 3);
        chk("wb_write3", write3, 32'h11);
        tick();
        wb_addr = 0;
        settle();
        chk("wb_r0_we3", 32'(we3), 0);
        tick();
        idle_inputs();

        // Issue r7, result one cycle later, written the cycle after, then free.
        iss_valid = 1; iss_addr = 7; q1_addr = 7;
        settle(); chk("iss7_busy", 32'(q1_busy), 1); tick();
        iss_valid = 0; ld_valid = 1; ld_addr = 7; ld_data = 32'hDEAD;
        settle(); chk("ld7_nobypass", 32'(we3), 0); tick();
        ld_valid = 0;
        settle(); chk("ld7_write3", write3, 32'hDEAD); chk("ld7_addr3", 32'(addr3), 7); tick();
        settle(); chk("ld7_free", 32'(q1_busy), 0); tick();

        // Starvation: WB always wants the port, two results queued.
        for (int i = 0; i < 16; i++) begin
            idle_inputs();
            wb_valid = !hold_prev; wb_addr = 5'(1 + i % 3); wb_data = 32'(i);
            if (i == 0) begin iss_valid = 1; iss_addr = 10; end
            if (i == 1) begin iss_valid = 1; iss_addr = 11; end
            if (i == 2) begin ld_valid = 1; ld_addr = 10; ld_data = 32'hA0; end
            if (i == 3) begin ld_valid = 1; ld_addr = 11; ld_data = 32'hB1; end
            settle();
            if (i == 4)  chk("starve_full", 32'(ld_ready), 0);
            if (i == 6)  chk("starve_hold", 32'(wb_hold), 1);
            if (i == 7)  chk("starve_pop10", 32'(addr3), 10);
            if (i == 12) chk("starve_pop11", 32'(addr3), 11);
            tick();
        end
        idle_inputs();

        // Issue r9 while its previous result is being written: stays pending.
        iss_valid = 1; iss_addr = 9; settle(); tick();
        iss_valid = 0; ld_valid = 1; ld_addr = 9; ld_data = 32'h99; settle(); tick();
        ld_valid = 0; iss_valid = 1; iss_addr = 9; settle(); tick();
        iss_valid = 0; qd_addr = 9;
        ld_valid = 1; ld_addr = 9; ld_data = 32'h9A;
        settle(); chk("r9_still_busy", 32'(qd_busy), 1); tick();
        ld_valid = 0; settle(); tick();

        // r0 result is swallowed; r0 never reads busy.
        ld_valid = 1; ld_addr = 0; ld_data = 32'hBAD; iss_valid = 1; iss_addr = 0;
        q1_addr = 0; q2_addr = 0;
        settle(); chk("r0_busy", 32'(q1_busy), 0); tick();
        idle_inputs();
        settle(); chk("r0_no_write", 32'(we3), 0); tick();

        // Mid-stream reset with two queued results and r5 pending.
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            wb_valid = !hold_prev; wb_addr = 2; wb_data = 32'(i);
            case (i)
                0: begin iss_valid = 1; iss_addr = 5;  end
                1: begin iss_valid = 1; iss_addr = 12; end
                2: begin iss_valid = 1; iss_addr = 13; end
                3: begin ld_valid = 1; ld_addr = 12; ld_data = 32'hC; end
                4: begin ld_valid = 1; ld_addr = 13; ld_data = 32'hD; end
                default: ;
            endcase
            settle(); tick();
        end
        idle_inputs();
        wb_valid = 1; wb_addr = 2; q1_addr = 5; q2_addr = 12;
        reset_n = 1'b0;
        settle();
        chk("mid_rst_we3", 32'(we3), 0);
        chk("mid_rst_ready", 32'(ld_ready), 0);
        chk("mid_rst_busy5", 32'(q1_busy), 0);
        tick();
        reset_n = 1'b1; wb_valid = 0;
        settle();
        chk("post_rst_ready", 32'(ld_ready), 1);
        chk("post_rst_empty", 32'(we3), 0);
        tick();
        inflight.delete();

        // Random traffic with a well-behaved pipeline and mul/div unit.
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] r;
            wb_valid = hold_prev ? 1'b0 : ($urandom_range(0, 99) < 65);
            wb_addr  = 5'($urandom_range(0, 31));
            wb_data  = $urandom();
            if (!ld_valid || ld_taken) begin
                if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
                    ld_valid = 1; ld_addr = inflight.pop_front(); ld_data = $urandom();
                end else if ($urandom_range(0, 24) == 0) begin
                    ld_valid = 1; ld_addr = 0; ld_data = $urandom();
                end else begin
                    ld_valid = 0;
                end
            end
            r = 5'($urandom_range(1, 31));
            iss_valid = ($urandom_range(0, 3) == 0) && !pend[r];
            iss_addr  = iss_valid ? r : 5'($urandom_range(0, 31));
            q1_addr = 5'($urandom_range(0, 31));
            q2_addr = ($urandom_range(0, 1) == 0) ? iss_addr : 5'($urandom_range(0, 31));
            qd_addr = 5'($urandom_range(0, 31));
            settle();
            tick();
            if (iss_valid && iss_addr != 5'd0) inflight.push_back(iss_addr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
